// File: rtl/enemy_shot_scheduler_if.sv
// enemy_shot_scheduler_if: groups the run enable, alive mask and shot outputs of the scheduler.
// Latency: none, wires only.
// Backpressure: none; the scheduler never stalls its consumer.
// Ports/signals: enable, alive_mask[CHANNELS] (game -> scheduler); shot[CHANNELS], shot_id,
//   busy, shots_total[16] (scheduler -> bullet drawers).
interface enemy_shot_scheduler_if #(
  parameter int CHANNELS = 8
);
  localparam int ID_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                enable;
  logic [CHANNELS-1:0] alive_mask;
  logic [CHANNELS-1:0] shot;
  logic [ID_W-1:0]     shot_id;
  logic                busy;
  logic [15:0]         shots_total;

  // master: the game/formation side driving enable and the alive mask
  modport master (
    output enable, alive_mask,
    input  shot, shot_id, busy, shots_total
  );

  // slave: the scheduler itself
  modport slave (
    input  enable, alive_mask,
    output shot, shot_id, busy, shots_total
  );
endinterface

// File: rtl/enemy_shot_scheduler.sv
// enemy_shot_scheduler: every PERIOD enabled cycles draws an LFSR sample, decides whether to fire and picks one alive enemy.
// Latency: shot rises PERIOD+1 cycles after IDLE entry (PERIOD IDLE + 1 PICK), is held PULSE_W cycles.
// Backpressure: none; enable only pauses IDLE counting, dropping the firing enemy's alive bit aborts the volley.
// Ports: pclk, rst (async, active high); bus.enable, bus.alive_mask in; bus.shot (one-hot, registered),
//   bus.shot_id (last firing channel), bus.busy (high in FIRE), bus.shots_total (saturating volley count) out.
module enemy_shot_scheduler #(
  parameter int          CHANNELS = 8,
  parameter int          PERIOD   = 3000,
  parameter int          PULSE_W  = 20,
  parameter int          PROB_NUM = 230,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input logic                  pclk,
  input logic                  rst,
  enemy_shot_scheduler_if.slave bus
);

  localparam int ID_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW    = ID_W + 1;
  localparam int PER_W = $clog2(PERIOD);
  localparam int PUL_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(PULSE_W - 1);
  // 9 bits so that 256 means "always fire" against an 8-bit sample
  localparam logic [8:0]       PROB     = 9'(PROB_NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PICK = 2'd1,
    S_FIRE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
  logic [PUL_W-1:0]    pul_cnt_q, pul_cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [CHANNELS-1:0] shot_q, shot_d;
  logic [ID_W-1:0]     shot_id_q, shot_id_d;
  logic                busy_q, busy_d;
  logic [15:0]         total_q, total_d;

  logic [7:0]          rnd_fire;
  logic [ID_W-1:0]     rnd_start;
  logic [CW-1:0]       cand;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_found;
  logic                fire_ok;
  logic                abort;

  // Galois LFSR, taps 0xB400; free-running, self-heals from the all-zero lock-up
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
    if (lfsr_q == 16'h0000) begin
      lfsr_d = SEED;
    end
  end

  assign rnd_fire  = lfsr_q[7:0];
  assign rnd_start = ID_W'(lfsr_q[15:8] % 8'(CHANNELS));

  // First alive channel at or above rnd_start, wrapping; cand is one bit wider so the sum never overflows
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = {1'b0, rnd_start} + CW'(k);
      if (cand >= CW'(CHANNELS)) begin
        cand = cand - CW'(CHANNELS);
      end
      if (!pick_found && bus.alive_mask[cand[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[ID_W-1:0];
      end
    end
  end

  // pick_found is equivalent to alive_mask != 0
  assign fire_ok = ({1'b0, rnd_fire} < PROB) && pick_found;
  assign abort   = !bus.alive_mask[shot_id_q];

  // State register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      per_cnt_q <= '0;
      pul_cnt_q <= '0;
      lfsr_q    <= SEED;
      shot_q    <= '0;
      shot_id_q <= '0;
      busy_q    <= 1'b0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      pul_cnt_q <= pul_cnt_d;
      lfsr_q    <= lfsr_d;
      shot_q    <= shot_d;
      shot_id_q <= shot_id_d;
      busy_q    <= busy_d;
      total_q   <= total_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && (per_cnt_q == PER_LAST)) begin
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        state_d = fire_ok ? S_FIRE : S_IDLE;
      end
      S_FIRE: begin
        if (abort || (pul_cnt_q == PUL_LAST)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counters and registered outputs
  always_comb begin
    per_cnt_d = per_cnt_q;
    pul_cnt_d = pul_cnt_q;
    shot_d    = shot_q;
    shot_id_d = shot_id_q;
    busy_d    = busy_q;
    total_d   = total_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
        end
      end
      S_PICK: begin
        // A miss leaves every output untouched, including the last shot_id
        if (fire_ok) begin
          shot_d           = '0;
          shot_d[pick_idx] = 1'b1;
          shot_id_d        = pick_idx;
          busy_d           = 1'b1;
          pul_cnt_d        = '0;
        end
      end
      S_FIRE: begin
        if (abort) begin
          // Target died mid-pulse: drop the line, the volley does not count
          shot_d    = '0;
          busy_d    = 1'b0;
          per_cnt_d = '0;
        end else if (pul_cnt_q == PUL_LAST) begin
          shot_d    = '0;
          busy_d    = 1'b0;
          per_cnt_d = '0;
          if (total_q != 16'hFFFF) begin
            total_d = total_q + 16'd1;
          end
        end else begin
          pul_cnt_d = pul_cnt_q + 1'b1;
        end
      end
      default: begin
        per_cnt_d = '0;
      end
    endcase
  end

  assign bus.shot        = shot_q;
  assign bus.shot_id     = shot_id_q;
  assign bus.busy        = busy_q;
  assign bus.shots_total = total_q;

endmodule

// File: tb/tb_enemy_shot_scheduler.sv
module tb_enemy_shot_scheduler;
  localparam int          C    = 8;
  localparam int          P    = 10;
  localparam int          W    = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  enemy_shot_scheduler_if #(.CHANNELS(C)) bus1 ();
  enemy_shot_scheduler_if #(.CHANNELS(C)) bus2 ();
  enemy_shot_scheduler_if #(.CHANNELS(C)) bus3 ();

  // Main device: always fires when something is alive
  enemy_shot_scheduler #(.CHANNELS(C), .PERIOD(P), .PULSE_W(W), .PROB_NUM(256), .SEED(SEED))
    u_dut1 (.pclk(pclk), .rst(rst), .bus(bus1));
  // Never fires
  enemy_shot_scheduler #(.CHANNELS(C), .PERIOD(P), .PULSE_W(W), .PROB_NUM(0), .SEED(SEED))
    u_dut2 (.pclk(pclk), .rst(rst), .bus(bus2));
  // Fires on roughly half the decisions
  enemy_shot_scheduler #(.CHANNELS(C), .PERIOD(P), .PULSE_W(W), .PROB_NUM(128), .SEED(SEED))
    u_dut3 (.pclk(pclk), .rst(rst), .bus(bus3));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    if (v == 16'h0000) return SEED;
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Rotate the doubled mask down by the start point; lowest set bit is the winner
  function automatic int pick_ch(input logic [15:0] l, input logic [C-1:0] m);
    int start;
    logic [2*C-1:0] dbl;
    start = int'(l[15:8]) % C;
    dbl   = {m, m} >> start;
    for (int i = 0; i < C; i++) begin
      if (dbl[i]) return (start + i) % C;
    end
    return -1;
  endfunction

  // Reference LFSR plus a volley model for the 50% device
  logic [15:0] m_lfsr;
  int s3, k3, m3_total;
  int q3[$];
  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      m_lfsr   <= SEED;
      s3       <= 0;
      k3       <= 0;
      m3_total <= 0;
      q3.delete();
    end else begin
      m_lfsr <= lfsr_next(m_lfsr);
      case (s3)
        0: if (k3 == P - 1) begin s3 <= 1; k3 <= 0; end else k3 <= k3 + 1;
        1: if ({1'b0, m_lfsr[7:0]} < 9'd128) begin
             s3 <= 2;
             k3 <= 0;
             q3.push_back(pick_ch(m_lfsr, 8'hFF));
           end else s3 <= 0;
        default: if (k3 == W - 1) begin s3 <= 0; k3 <= 0; m3_total <= m3_total + 1; end
                 else k3 <= k3 + 1;
      endcase
    end
  end

  // Monitors for the two side devices
  logic [C-1:0] prev3 = '0;
  int hi2 = 0;
  always @(negedge pclk) begin
    int e;
    if (rst) begin
      prev3 <= '0;
    end else begin
      if (bus2.shot != '0 || bus2.busy) hi2 <= hi2 + 1;
      if (bus3.shot != '0 && prev3 == '0) begin
        if (q3.size() == 0) begin
          check("dut3_unexpected_shot", 32'(bus3.shot), 32'd0);
        end else begin
          e = q3.pop_front();
          check("dut3_shot", 32'(bus3.shot), 32'(1 << e));
          check("dut3_id", 32'(bus3.shot_id), 32'(e));
        end
      end
      prev3 <= bus3.shot;
    end
  end

  // Main scoreboard
  int sb[$];
  int exp_total = 0;
  int wrap_seen = 0;

  typedef struct {
    logic [7:0] mask;
    int         gap;
    bit         abort;
    bit         fire;
  } vec_t;
  vec_t vt[16];

  // Starts at IDLE entry; ends at the next IDLE entry
  task automatic volley(input logic [7:0] mask, input int gap, input bit abort, input bit exp_fire);
    int early = 0;
    int hold  = 0;
    int ch;
    int ch_e;
    logic [7:0] exp_shot;
    bus1.alive_mask = mask;
    bus1.enable     = 1'b1;
    for (int e = 1; e <= P + gap; e++) begin
      @(posedge pclk); #1;
      if (bus1.shot != '0 || bus1.busy) early++;
      if (gap > 0 && e == 2) bus1.enable = 1'b0;
      if (gap > 0 && e == 2 + gap) bus1.enable = 1'b1;
    end
    check("no_early_shot", 32'(early), 32'd0);
    // Now in the decision cycle: the model LFSR equals the value the device samples
    ch = pick_ch(m_lfsr, mask);
    if (mask == 8'h03 && (int'(m_lfsr[15:8]) % C) >= 2) wrap_seen++;
    if (exp_fire) sb.push_back(ch);
    @(posedge pclk); #1;
    if (!exp_fire) begin
      check("miss_shot", 32'(bus1.shot), 32'd0);
      check("miss_busy", 32'(bus1.busy), 32'd0);
      check("miss_total", 32'(bus1.shots_total), 32'(exp_total));
      return;
    end
    ch_e     = sb.pop_front();
    exp_shot = 8'(1 << ch_e);
    check("rise_shot", 32'(bus1.shot), 32'(exp_shot));
    check("rise_id", 32'(bus1.shot_id), 32'(ch_e));
    check("rise_busy", 32'(bus1.busy), 32'd1);
    if (abort) begin
      @(posedge pclk); #1;
      check("abort_pre_shot", 32'(bus1.shot), 32'(exp_shot));
      bus1.alive_mask = mask & ~exp_shot;
      @(posedge pclk); #1;
      check("abort_shot", 32'(bus1.shot), 32'd0);
      check("abort_busy", 32'(bus1.busy), 32'd0);
      check("abort_total", 32'(bus1.shots_total), 32'(exp_total));
      return;
    end
    for (int i = 1; i < W; i++) begin
      @(posedge pclk); #1;
      if (bus1.shot == exp_shot && bus1.busy) hold++;
    end
    check("pulse_hold", 32'(hold), 32'(W - 1));
    @(posedge pclk); #1;
    exp_total++;
    check("fall_shot", 32'(bus1.shot), 32'd0);
    check("fall_busy", 32'(bus1.busy), 32'd0);
    check("fall_total", 32'(bus1.shots_total), 32'(exp_total));
    check("id_persists", 32'(bus1.shot_id), 32'(ch_e));
  endtask

  initial begin
    vt[0]  = '{8'hFF, 0, 1'b0, 1'b1};
    vt[1]  = '{8'hFF, 0, 1'b0, 1'b1};
    vt[2]  = '{8'hFF, 0, 1'b0, 1'b1};
    vt[3]  = '{8'h04, 0, 1'b0, 1'b1};
    vt[4]  = '{8'h04, 0, 1'b0, 1'b1};
    vt[5]  = '{8'h00, 0, 1'b0, 1'b0};
    vt[6]  = '{8'h00, 0, 1'b0, 1'b0};
    vt[7]  = '{8'h03, 0, 1'b0, 1'b1};
    vt[8]  = '{8'h03, 0, 1'b0, 1'b1};
    vt[9]  = '{8'h03, 0, 1'b0, 1'b1};
    vt[10] = '{8'h03, 0, 1'b0, 1'b1};
    vt[11] = '{8'h03, 0, 1'b0, 1'b1};
    vt[12] = '{8'h03, 0, 1'b0, 1'b1};
    vt[13] = '{8'hFF, 0, 1'b1, 1'b1};
    vt[14] = '{8'hFF, 0, 1'b0, 1'b1};
    vt[15] = '{8'hFF, 5, 1'b0, 1'b1};

    bus1.enable = 1'b1; bus1.alive_mask = 8'hFF;
    bus2.enable = 1'b1; bus2.alive_mask = 8'hFF;
    bus3.enable = 1'b1; bus3.alive_mask = 8'hFF;
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_shot", 32'(bus1.shot), 32'd0);
    check("rst_id", 32'(bus1.shot_id), 32'd0);
    check("rst_busy", 32'(bus1.busy), 32'd0);
    check("rst_total", 32'(bus1.shots_total), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 16; v++) begin
      volley(vt[v].mask, vt[v].gap, vt[v].abort, vt[v].fire);
    end
    check("wrap_seen", 32'(wrap_seen > 0), 32'd1);

    // Reset in the middle of a pulse clears everything without a clock edge
    bus1.alive_mask = 8'hFF;
    repeat (P + 2) @(posedge pclk);
    #1;
    check("midfire_busy", 32'(bus1.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_shot", 32'(bus1.shot), 32'd0);
    check("async_rst_busy", 32'(bus1.busy), 32'd0);
    check("async_rst_total", 32'(bus1.shots_total), 32'd0);
    check("async_rst_id", 32'(bus1.shot_id), 32'd0);
    @(posedge pclk); #1;
    rst = 1'b0;
    exp_total = 0;
    sb.delete();
    volley(8'hFF, 0, 1'b0, 1'b1);

    // Long run for the never-fire and half-probability devices
    repeat (1000 * (P + 1)) @(posedge pclk);
    @(negedge pclk); #1;
    check("never_fire_active_cycles", 32'(hi2), 32'd0);
    check("never_fire_total", 32'(bus2.shots_total), 32'd0);
    check("half_prob_total", 32'(bus3.shots_total), 32'(m3_total));
    check("half_prob_pending", 32'(q3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/enemy_shot_scheduler.md
Name: enemy_shot_scheduler

Overview:
Parametrised, multi-channel successor to the single-output random shot generator. Every PERIOD cycles it draws from an internal LFSR, decides with programmable probability whether the enemy formation fires, and picks one alive enemy channel pseudo-randomly. It then asserts that channel's one-hot shot line for a fixed PULSE_W cycles. It sits between the enemy position/alive logic and the per-enemy bullet drawers, and replaces the simulation-only $urandom source with synthesizable randomness.

Parameters:
CHANNELS, 8, number of enemy channels (1..16).
PERIOD, 3000, IDLE cycles between fire decisions (>=2).
PULSE_W, 20, cycles a shot line stays high (>=1).
PROB_NUM, 230, fire if random byte < PROB_NUM; range 0..256 (0 = never, 256 = always).
SEED, 16'hACE1, LFSR reset/reload value (non-zero).

Ports:
pclk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  scheduler run enable (game in play).
alive_mask  input  CHANNELS  bit i = 1 when enemy i may fire.
shot  output  CHANNELS  one-hot, registered; high for the firing enemy.
shot_id  output  $clog2(CHANNELS) (min 1)  index of the current/last firing channel.
busy  output  1  high while in FIRE.
shots_total  output  16  count of completed volleys, saturating at 16'hFFFF.

Behaviour:
- Reset, asynchronous: state = IDLE, period counter = 0, pulse counter = 0, lfsr = SEED. shot = 0, shot_id = 0, busy = 0, shots_total = 0.
- LFSR: 16-bit Galois, taps 0xB400. Advances every clock out of reset regardless of state or enable. If it ever holds 0, it reloads SEED on the next clock.
- rnd_fire = lfsr[7:0]. rnd_start = lfsr[15:8] % CHANNELS.
- IDLE:
  - enable = 1: period counter increments each cycle.
  - When the counter is PERIOD-1, go to PICK and clear the counter.
  - enable = 0: the counter holds.
- PICK, exactly 1 cycle, sampled that cycle:
  - Fire when {1'b0,rnd_fire} < PROB_NUM and alive_mask != 0.
  - Channel = first set bit of alive_mask searching upward from rnd_start, wrapping modulo CHANNELS.
  - Fire: register shot = one-hot(channel), shot_id = channel, busy = 1, pulse counter = 0, go to FIRE.
  - No fire (probability miss or mask all zero): back to IDLE, outputs unchanged, shots_total unchanged.
- FIRE:
  - shot is held exactly PULSE_W cycles. The pulse counter increments each cycle.
  - At PULSE_W-1: shot = 0, busy = 0, shots_total += 1 (saturating), go to IDLE with the period counter at 0.
- Abort: if alive_mask[shot_id] drops during FIRE, shot and busy go 0 on the next edge and the state returns to IDLE. shots_total is not incremented.
- enable deasserted during PICK or FIRE does not cancel the volley; only IDLE counting is gated.
- Cadence, enable held high: shot rises PERIOD+1 cycles after IDLE entry (PERIOD IDLE cycles plus 1 PICK cycle). Consecutive volleys are PERIOD+1+PULSE_W cycles apart, edge to edge.
- At most one shot bit is ever high. shot_id persists after the pulse ends.
- Reset asserted mid-operation returns everything to reset values immediately; no partial pulse resumes.

Test Plan:
1. PERIOD=10, PULSE_W=3, PROB_NUM=256, alive_mask=8'hFF, enable=1 -> shot one-hot rises at cycle 11 after reset release, stays high 3 cycles, repeats every 14 cycles; shots_total counts 1,2,3.
2. PROB_NUM=0, 1000 periods -> shot never asserts, shots_total stays 0, busy stays 0.
3. alive_mask=8'b0000_0100, PROB_NUM=256 -> every volley has shot=8'h04 and shot_id=2. Then alive_mask=0 -> no volleys, state returns to IDLE after each PICK.
4. Force lfsr[15:8] % 8 = 6 with alive_mask=8'b0000_0011 -> wrap search selects channel 0, shot=8'h01.
5. Clear alive_mask[shot_id] in the second FIRE cycle -> shot=0 next edge, shots_total unchanged. The following volley arrives PERIOD+1 cycles later.
6. Drop enable for 5 cycles mid-IDLE -> shot rise delayed by exactly 5 cycles. Assert rst mid-FIRE -> shot=0 and shots_total=0 immediately, without waiting for a clock edge.
